// File: rtl/bpu_pkg.sv
// Shared encodings for the branch target buffer: counter values and flush FSM states.
package bpu_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bpu_flush_state_t;

endpackage

// File: rtl/bpu_btb_if.sv
// PC-to-BPU bus: fetch lookup (pc_i -> pr/pr_addr) plus the execute-stage training port.
interface bpu_btb_if;

    logic [31:0] pc_i;
    logic        pr;
    logic [31:0] pr_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output pc_i, upd_valid, upd_pc, upd_taken, upd_target,
        input  pr, pr_addr
    );

    modport slave (
        input  pc_i, upd_valid, upd_pc, upd_taken, upd_target,
        output pr, pr_addr
    );

endinterface

// File: rtl/bpu_sat_ctr.sv
// 2-bit saturating direction counter next-state logic.
module bpu_sat_ctr
    import bpu_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit counters, combinational lookup and a one-entry-per-cycle flush sweep.
// Optional BPU_BTB_STATS_EN adds lookup/hit/update/mispredict counters and the upd_mispred input.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    bpu_btb_if.slave    bus,
    input  logic        flush_i,
    output logic        busy
`ifdef BPU_BTB_STATS_EN
    ,
    input  logic        upd_mispred,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispred
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [29:0]        r_tgt [ENTRIES];
    logic [1:0]         r_ctr [ENTRIES];

    bpu_flush_state_t   r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;

    logic [IDX_W-1:0]   w_lidx, w_uidx;
    logic [TAG_W-1:0]   w_ltag, w_utag;
    logic               w_hit, w_uhit, w_upd_acc;
    logic [1:0]         w_ctr_nxt;

    assign busy = (r_state == SWEEP);

    // Lookup from registered state; suppressed while the sweep runs
    assign w_lidx      = bus.pc_i[IDX_W+1:2];
    assign w_ltag      = bus.pc_i[31:IDX_W+2];
    assign w_hit       = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign bus.pr      = w_hit && r_ctr[w_lidx][1] && !busy;
    assign bus.pr_addr = bus.pr ? {r_tgt[w_lidx], 2'b00} : 32'h0;

    // Flush wins over a same-cycle update; updates during the sweep are dropped
    assign w_uidx    = bus.upd_pc[IDX_W+1:2];
    assign w_utag    = bus.upd_pc[31:IDX_W+2];
    assign w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_upd_acc = bus.upd_valid && (r_state == IDLE) && !flush_i;

    bpu_sat_ctr u_sat_ctr (
        .ctr     (r_ctr[w_uidx]),
        .taken   (bus.upd_taken),
        .ctr_nxt (w_ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (flush_i) begin
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                if (flush_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == IDX_W'(ENTRIES - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + IDX_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_tag[IDX_W'(i)] <= '0;
                r_tgt[IDX_W'(i)] <= '0;
                r_ctr[IDX_W'(i)] <= CTR_RESET;
            end
        end else if (busy) begin
            r_valid[r_cnt] <= 1'b0;
            r_ctr[r_cnt]   <= CTR_RESET;
        end else if (w_upd_acc) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_nxt;
                if (bus.upd_taken) r_tgt[w_uidx] <= bus.upd_target[31:2];
            end else if (bus.upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= bus.upd_target[31:2];
                r_ctr[w_uidx]   <= CTR_ALLOC;
            end
        end
    end

`ifdef BPU_BTB_STATS_EN
    logic [31:0] r_stat_lookups, r_stat_hits, r_stat_updates, r_stat_mispred;

    // Free-running counters; flush leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
            r_stat_updates <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (!busy)                 r_stat_lookups <= r_stat_lookups + 32'd1;
            if (!busy && w_hit)        r_stat_hits    <= r_stat_hits + 32'd1;
            if (w_upd_acc)             r_stat_updates <= r_stat_updates + 32'd1;
            if (w_upd_acc && upd_mispred) r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_lookups = r_stat_lookups;
    assign stat_hits    = r_stat_hits;
    assign stat_updates = r_stat_updates;
    assign stat_mispred = r_stat_mispred;
`endif

endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
- Branch predictor feeding the fetch PC register: the responder on the PC-to-BPU interface.
- The PC register drives the current fetch PC in. This block returns a taken prediction (pr) and its target (pr_addr) in the same cycle.
- Prediction uses a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- The execute/commit stage trains the table through an update port.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, range 4..1024.
- IDX_W, $clog2(ENTRIES), index width (derived; do not override).
- TAG_W, 30-IDX_W, tag width; the tag is pc[31:IDX_W+2].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- pc_i  input  32  current fetch PC (the PC register's pc_o)
- pr  output  1  predict taken for pc_i (combinational)
- pr_addr  output  32  predicted target; 0 when pr=0
- upd_valid  input  1  one resolved control-flow instruction this cycle
- upd_pc  input  32  PC of the resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  32  actual target (meaningful when upd_taken=1)
- flush_i  input  1  synchronous invalidate of all entries
- busy  output  1  high while flush sweep in progress

Behaviour:
- Entry fields: valid, tag[TAG_W], target[31:2], ctr[1:0]. Index = pc[IDX_W+1:2]; pc[1:0] is ignored.
- Lookup is combinational from registered table state:
  - hit = valid && tag==pc_i tag;
  - pr = hit && ctr[1];
  - pr_addr = pr ? {target,2'b00} : 0.
- pr is forced 0 while busy=1.
- Update (registered, takes effect at the next posedge; a same-cycle lookup sees the old contents):
  - Hit, taken: ctr saturating +1 (max 3); target <= upd_target[31:2].
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate or replace; valid=1, tag, target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Reset (async, rst_n=0):
  - all valid=0, all ctr=2'b01;
  - pr=0, pr_addr=0, busy=0;
  - FSM to IDLE;
  - any in-progress flush is abandoned.
- Flush FSM:
  - States IDLE, SWEEP.
  - IDLE + flush_i=1: go to SWEEP; sweep counter = 0; busy=1.
  - SWEEP: each cycle clear valid[cnt] and set ctr[cnt]=01, then cnt+1. When cnt==ENTRIES-1, the clear is done and the FSM returns to IDLE (busy=0 the following cycle).
  - Sweep latency is exactly ENTRIES cycles.
  - upd_valid is ignored during SWEEP (dropped, not queued).
  - flush_i asserted during SWEEP restarts cnt at 0.
- Simultaneous flush_i=1 and upd_valid=1 in IDLE: the flush wins and the update is dropped.
- Back-to-back updates to the same index on consecutive cycles each see the previous cycle's result; there is no lost update.
- Storage is a flop array (no SRAM); the sweep exists so the flop array can later migrate to SRAM without changing the interface.

Optional Feature:
- Macro: BPU_BTB_STATS_EN.
- Defined: adds outputs stat_lookups[31:0], stat_hits[31:0], stat_updates[31:0], stat_mispred[31:0], plus input upd_mispred.
  - stat_lookups increments every cycle busy=0.
  - stat_hits increments when hit=1 and busy=0.
  - stat_updates increments on each accepted update.
  - stat_mispred increments on an accepted update with upd_mispred=1.
  - All counters are free-running, wrap at 2^32, and reset to 0 on rst_n; flush does not clear them.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bpu_pkg holds:
  - counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - CTR_RESET=CTR_WNT, CTR_ALLOC=CTR_WT;
  - FSM state typedef bpu_flush_state_t {IDLE, SWEEP}.
- One sub-module, bpu_sat_ctr: combinational 2-bit saturating next-state (inputs ctr, taken; output ctr_nxt). It is instantiated once on the update path.

Test Plan:
- Reset, then pc_i=0x100 -> pr=0, pr_addr=0, busy=0.
- Update pc=0x100 taken target=0x200, next cycle pc_i=0x100 -> pr=1, pr_addr=0x200. The same-cycle lookup during the update still shows pr=0.
- From ctr=10: two not-taken updates at 0x100 -> after the first, ctr=01 and pr=0; after the second, ctr=00. Four taken updates from there -> ctr saturates at 11, and pr_addr follows the last target.
- Alias: with the entry at 0x100 valid, lookup 0x100+4*ENTRIES -> pr=0. A taken update there replaces the entry, so 0x100 then misses.
- flush_i pulse -> busy=1 for exactly ENTRIES cycles and pr=0 throughout. A concurrent upd_valid is dropped. Afterwards every previously trained PC misses.
- rst_n low for 1 cycle mid-sweep (cnt=10) -> busy=0 immediately and all entries invalid. With BPU_BTB_STATS_EN: all four stats read 0.
